rv32i_pipe_control: RTL and testbench

- Pipelined RV32I control unit for the 5-stage core (F, D, E, M, WB).
- Decodes the D-stage instruction fields combinationally into one control bundle.
- Carries the bundle through E, M and WB pipeline registers, so each datapath stage receives the controls of the instruction it currently holds.
- Accepts per-stage stall/flush from the hazard unit; reports E/M register-write activity back to it.

---
 rtl/rv32i_ctrl_pkg.sv | 94 +++++++++
 rtl/rv32i_ctrl_decoder.sv | 82 ++++++++
 rtl/rv32i_pipe_control.sv | 85 ++++++++
 tb/tb_rv32i_pipe_control.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings and control bundles for the
// RV32I pipeline control unit.
package rv32i_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_sel_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_IMM = 2'd3
   } reg_sel_e;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'd0,
      PC_TARGET = 2'd1,
      PC_ALU    = 2'd2
   } pc_sel_e;

   // Fields drop off as they are consumed stage by stage.
   typedef struct packed {
      reg_sel_e reg_sel;
      logic     reg_we;
   } wb_ctrl_t;

   typedef struct packed {
      logic [2:0] dmem_sel;
      logic       dmem_we;
      wb_ctrl_t   w;
   } mem_ctrl_t;

   typedef struct packed {
      alu_op_e   alu;
      logic      rs1_sel;
      logic      rs2_sel;
      logic      branch;
      logic      jal;
      logic      jalr;
      mem_ctrl_t m;
   } ctrl_t;

   localparam wb_ctrl_t  WB_NOP   = '0;
   localparam mem_ctrl_t MEM_NOP  = '0;
   localparam ctrl_t     CTRL_NOP = '0;

   function automatic alu_op_e alu_from_f3(
      input logic [2:0] f3,
      input logic       alt
   );
      alu_op_e op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv32i_ctrl_decoder.sv
// Combinational D-stage decode of opcode/funct
// fields into the control bundle.
module rv32i_ctrl_decoder
   import rv32i_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [6:0] funct7,
   input  logic [2:0] funct3,
   output imm_sel_e   imm_sel,
   output ctrl_t      ctrl
);

   logic alt;
   logic unused_f7;

   assign alt       = funct7[5];
   assign unused_f7 = ^{funct7[6], funct7[4:0]};

   always_comb begin
      ctrl    = CTRL_NOP;
      imm_sel = IMM_I;
      unique case (1'b1)
         (opcode == OP_R): begin
            ctrl.alu        = alu_from_f3(funct3, alt);
            ctrl.m.w.reg_we = 1'b1;
         end
         (opcode == OP_I): begin
            // Only SRAI uses funct7; ADDI never becomes SUB.
            ctrl.alu        = alu_from_f3(funct3,
                                 alt && (funct3 == 3'b101));
            ctrl.rs2_sel    = 1'b1;
            ctrl.m.w.reg_we = 1'b1;
         end
         (opcode == OP_LOAD): begin
            ctrl.rs2_sel     = 1'b1;
            ctrl.m.dmem_sel  = funct3;
            ctrl.m.w.reg_sel = WB_MEM;
            ctrl.m.w.reg_we  = 1'b1;
         end
         (opcode == OP_STORE): begin
            imm_sel         = IMM_S;
            ctrl.rs2_sel    = 1'b1;
            ctrl.m.dmem_sel = funct3;
            ctrl.m.dmem_we  = 1'b1;
         end
         (opcode == OP_BRANCH): begin
            imm_sel     = IMM_B;
            ctrl.alu    = ALU_SUB;
            ctrl.branch = 1'b1;
         end
         (opcode == OP_JAL): begin
            imm_sel          = IMM_J;
            ctrl.jal         = 1'b1;
            ctrl.m.w.reg_sel = WB_PC4;
            ctrl.m.w.reg_we  = 1'b1;
         end
         (opcode == OP_JALR): begin
            ctrl.rs2_sel     = 1'b1;
            ctrl.jalr        = 1'b1;
            ctrl.m.w.reg_sel = WB_PC4;
            ctrl.m.w.reg_we  = 1'b1;
         end
         (opcode == OP_LUI): begin
            imm_sel         = IMM_U;
            ctrl.alu        = ALU_PASSB;
            ctrl.rs2_sel    = 1'b1;
            ctrl.m.w.reg_we = 1'b1;
         end
         (opcode == OP_AUIPC): begin
            imm_sel         = IMM_U;
            ctrl.rs1_sel    = 1'b1;
            ctrl.rs2_sel    = 1'b1;
            ctrl.m.w.reg_we = 1'b1;
         end
         default: begin
            ctrl    = CTRL_NOP;
            imm_sel = IMM_I;
         end
      endcase
   end

endmodule

// File: rtl/rv32i_pipe_control.sv
// Pipelined RV32I control: decode plus E/M/WB
// control registers with stall/flush.
module rv32i_pipe_control
   import rv32i_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [6:0] funct7,
   input  logic [2:0] funct3,
   input  logic       jump,
   input  logic       stall_E,
   input  logic       stall_M,
   input  logic       stall_WB,
   input  logic       flush_E,
   input  logic       flush_M,
   input  logic       flush_WB,
   output logic [2:0] imm_SEL,
   output logic [3:0] ALU_SEL,
   output logic       rs1_SEL,
   output logic       rs2_SEL,
   output logic [1:0] pc_SEL,
   output logic [2:0] dmem_SEL,
   output logic       dmem_WE,
   output logic [1:0] reg_SEL,
   output logic       reg_WE,
   output logic [1:0] reg_RD
);

   imm_sel_e  dec_imm;
   ctrl_t     dec_ctrl;
   ctrl_t     ex_q;
   mem_ctrl_t mem_q;
   wb_ctrl_t  wb_q;
   pc_sel_e   pc_sel;

   rv32i_ctrl_decoder u_dec (
      .opcode  (opcode),
      .funct7  (funct7),
      .funct3  (funct3),
      .imm_sel (dec_imm),
      .ctrl    (dec_ctrl)
   );

   always_ff @(posedge clk) begin
      if (reset || flush_E)
         ex_q <= CTRL_NOP;
      else if (!stall_E)
         ex_q <= dec_ctrl;
   end

   always_ff @(posedge clk) begin
      if (reset || flush_M)
         mem_q <= MEM_NOP;
      else if (!stall_M)
         mem_q <= ex_q.m;
   end

   always_ff @(posedge clk) begin
      if (reset || flush_WB)
         wb_q <= WB_NOP;
      else if (!stall_WB)
         wb_q <= mem_q.w;
   end

   always_comb begin
      pc_sel = PC_PLUS4;
      if (ex_q.jalr)
         pc_sel = PC_ALU;
      else if (ex_q.jal || (ex_q.branch && jump))
         pc_sel = PC_TARGET;
   end

   assign imm_SEL  = dec_imm;
   assign ALU_SEL  = ex_q.alu;
   assign rs1_SEL  = ex_q.rs1_sel;
   assign rs2_SEL  = ex_q.rs2_sel;
   assign pc_SEL   = pc_sel;
   assign dmem_SEL = mem_q.dmem_sel;
   assign dmem_WE  = mem_q.dmem_we;
   assign reg_SEL  = wb_q.reg_sel;
   assign reg_WE   = wb_q.reg_we;
   assign reg_RD   = {mem_q.w.reg_we, ex_q.m.w.reg_we};

endmodule

// File: tb/tb_rv32i_pipe_control.sv
// Bench for rv32i_pipe_control: directed literal
// checks plus random traffic against a model.
module tb_rv32i_pipe_control;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = '0;
   logic [6:0] funct7 = '0;
   logic [2:0] funct3 = '0;
   logic       jump = 1'b0;
   logic       stall_E = 1'b0;
   logic       stall_M = 1'b0;
   logic       stall_WB = 1'b0;
   logic       flush_E = 1'b0;
   logic       flush_M = 1'b0;
   logic       flush_WB = 1'b0;
   logic [2:0] imm_SEL;
   logic [3:0] ALU_SEL;
   logic       rs1_SEL;
   logic       rs2_SEL;
   logic [1:0] pc_SEL;
   logic [2:0] dmem_SEL;
   logic       dmem_WE;
   logic [1:0] reg_SEL;
   logic       reg_WE;
   logic [1:0] reg_RD;

   always #5 clk = ~clk;

   rv32i_pipe_control dut (
      .clk      (clk),
      .reset    (reset),
      .opcode   (opcode),
      .funct7   (funct7),
      .funct3   (funct3),
      .jump     (jump),
      .stall_E  (stall_E),
      .stall_M  (stall_M),
      .stall_WB (stall_WB),
      .flush_E  (flush_E),
      .flush_M  (flush_M),
      .flush_WB (flush_WB),
      .imm_SEL  (imm_SEL),
      .ALU_SEL  (ALU_SEL),
      .rs1_SEL  (rs1_SEL),
      .rs2_SEL  (rs2_SEL),
      .pc_SEL   (pc_SEL),
      .dmem_SEL (dmem_SEL),
      .dmem_WE  (dmem_WE),
      .reg_SEL  (reg_SEL),
      .reg_WE   (reg_WE),
      .reg_RD   (reg_RD)
   );

   // The model tracks raw instruction fields per stage;
   // opcode 0 stands for a bubble.
   typedef struct packed {
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
   } ins_t;

   int   total = 0;
   int   bad = 0;
   bit   live = 1'b0;
   ins_t se = '0;
   ins_t sm = '0;
   ins_t sw = '0;

   function automatic int f_imm(ins_t i);
      case (i.op)
         7'h23:        return 1;
         7'h63:        return 2;
         7'h37, 7'h17: return 3;
         7'h6f:        return 4;
         default:      return 0;
      endcase
   endfunction

   function automatic int f_alu(ins_t i);
      int b;
      b = (i.f3 == 0) ? 0 :
          (i.f3 < 6) ? int'(i.f3) + 1 : int'(i.f3) + 2;
      case (i.op)
         7'h33: begin
            if (i.f7[5] && i.f3 == 0) return 1;
            if (i.f7[5] && i.f3 == 5) return 7;
            return b;
         end
         7'h13: begin
            if (i.f7[5] && i.f3 == 5) return 7;
            return b;
         end
         7'h63:   return 1;
         7'h37:   return 10;
         default: return 0;
      endcase
   endfunction

   function automatic int f_rs2(ins_t i);
      return int'(i.op inside
         {7'h13, 7'h03, 7'h23, 7'h67, 7'h37, 7'h17});
   endfunction

   function automatic int f_rwe(ins_t i);
      return int'(i.op inside
         {7'h33, 7'h13, 7'h03, 7'h6f, 7'h67, 7'h37, 7'h17});
   endfunction

   function automatic int f_rsel(ins_t i);
      if (i.op == 7'h03) return 1;
      if (i.op == 7'h6f || i.op == 7'h67) return 2;
      return 0;
   endfunction

   function automatic int f_dsel(ins_t i);
      if (i.op == 7'h03 || i.op == 7'h23)
         return int'(i.f3);
      return 0;
   endfunction

   function automatic int f_pc(ins_t i, logic j);
      if (i.op == 7'h67) return 2;
      if (i.op == 7'h6f) return 1;
      if (i.op == 7'h63 && j) return 1;
      return 0;
   endfunction

   task automatic chk(string nm, logic [31:0] act,
                      logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d",
                  nm, act, exp);
      end
   endtask

   task automatic tick();
      ins_t d, ne, nm, nw;
      #1;
      if (live) begin
         d = '{opcode, funct3, funct7};
         chk("imm_SEL", 32'(imm_SEL), f_imm(d));
         chk("ALU_SEL", 32'(ALU_SEL), f_alu(se));
         chk("rs1_SEL", 32'(rs1_SEL),
             int'(se.op == 7'h17));
         chk("rs2_SEL", 32'(rs2_SEL), f_rs2(se));
         chk("pc_SEL", 32'(pc_SEL), f_pc(se, jump));
         chk("dmem_SEL", 32'(dmem_SEL), f_dsel(sm));
         chk("dmem_WE", 32'(dmem_WE),
             int'(sm.op == 7'h23));
         chk("reg_SEL", 32'(reg_SEL), f_rsel(sw));
         chk("reg_WE", 32'(reg_WE), f_rwe(sw));
         chk("reg_RD", 32'(reg_RD),
             2 * f_rwe(sm) + f_rwe(se));
      end
      @(posedge clk);
      d  = '{opcode, funct3, funct7};
      ne = flush_E ? '0 : stall_E ? se : d;
      nm = flush_M ? '0 : stall_M ? sm : se;
      nw = flush_WB ? '0 : stall_WB ? sw : sm;
      if (reset) begin
         se = '0; sm = '0; sw = '0;
         live = 1'b1;
      end else begin
         se = ne; sm = nm; sw = nw;
      end
      @(negedge clk);
   endtask

   task automatic set_ins(logic [6:0] o, logic [2:0] f3,
                          logic [6:0] f7);
      opcode = o; funct3 = f3; funct7 = f7;
   endtask

   logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23,
      7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};

   initial begin
      @(negedge clk);
      tick();
      tick();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("rst dmem_WE", 32'(dmem_WE), 0);
         chk("rst reg_WE", 32'(reg_WE), 0);
         chk("rst reg_RD", 32'(reg_RD), 0);
         chk("rst pc_SEL", 32'(pc_SEL), 0);
         chk("rst ALU_SEL", 32'(ALU_SEL), 0);
         chk("rst reg_SEL", 32'(reg_SEL), 0);
         chk("rst dmem_SEL", 32'(dmem_SEL), 0);
         tick();
      end

      set_ins(7'h33, 3'b000, 7'h20);
      tick();
      set_ins(7'h00, 3'b000, 7'h00);
      #1;
      chk("sub ALU_SEL", 32'(ALU_SEL), 1);
      chk("sub rs2_SEL", 32'(rs2_SEL), 0);
      chk("sub reg_RD E", 32'(reg_RD), 1);
      tick();
      chk("sub reg_RD M", 32'(reg_RD), 2);
      tick();
      chk("sub reg_WE", 32'(reg_WE), 1);
      chk("sub reg_SEL", 32'(reg_SEL), 0);

      set_ins(7'h03, 3'b010, 7'h00);
      #1;
      chk("lw imm_SEL", 32'(imm_SEL), 0);
      tick();
      set_ins(7'h00, 3'b000, 7'h00);
      #1;
      chk("lw ALU_SEL", 32'(ALU_SEL), 0);
      chk("lw rs2_SEL", 32'(rs2_SEL), 1);
      tick();
      chk("lw dmem_SEL", 32'(dmem_SEL), 2);
      chk("lw dmem_WE", 32'(dmem_WE), 0);
      tick();
      chk("lw reg_SEL", 32'(reg_SEL), 1);
      chk("lw reg_WE", 32'(reg_WE), 1);

      set_ins(7'h63, 3'b000, 7'h00);
      tick();
      set_ins(7'h00, 3'b000, 7'h00);
      jump = 1'b1;
      #1;
      chk("beq taken", 32'(pc_SEL), 1);
      jump = 1'b0;
      #1;
      chk("beq not taken", 32'(pc_SEL), 0);
      set_ins(7'h67, 3'b000, 7'h00);
      tick();
      set_ins(7'h00, 3'b000, 7'h00);
      jump = 1'b1;
      #1;
      chk("jalr j1", 32'(pc_SEL), 2);
      jump = 1'b0;
      #1;
      chk("jalr j0", 32'(pc_SEL), 2);

      set_ins(7'h23, 3'b010, 7'h00);
      tick();
      set_ins(7'h00, 3'b000, 7'h00);
      flush_M = 1'b1;
      tick();
      flush_M = 1'b0;
      #1;
      chk("sw flushM dmem_WE", 32'(dmem_WE), 0);
      tick();

      set_ins(7'h23, 3'b010, 7'h00);
      tick();
      set_ins(7'h00, 3'b000, 7'h00);
      stall_E = 1'b1;
      #1;
      chk("sw stall c1", 32'(rs2_SEL), 1);
      tick();
      chk("sw stall c2", 32'(rs2_SEL), 1);
      tick();
      stall_E = 1'b0;
      #1;
      chk("sw stall c3", 32'(rs2_SEL), 1);
      chk("sw stall ALU", 32'(ALU_SEL), 0);
      tick();
      chk("sw released", 32'(rs2_SEL), 0);

      set_ins(7'h33, 3'b000, 7'h20);
      tick();
      stall_E = 1'b1;
      flush_E = 1'b1;
      tick();
      stall_E = 1'b0;
      flush_E = 1'b0;
      #1;
      chk("flush beats stall", 32'(ALU_SEL), 0);
      chk("flush beats stall RD", 32'(reg_RD[0]), 0);

      set_ins(7'h33, 3'b000, 7'h00);
      tick();
      tick();
      stall_E = 1'b1;
      stall_M = 1'b1;
      stall_WB = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      stall_E = 1'b0;
      stall_M = 1'b0;
      stall_WB = 1'b0;
      set_ins(7'h00, 3'b000, 7'h00);
      #1;
      chk("rst in stall RD", 32'(reg_RD), 0);
      chk("rst in stall WE", 32'(reg_WE), 0);

      for (int n = 0; n < 4000; n++) begin
         int r;
         r = int'($urandom_range(0, 11));
         if (r < 9)
            opcode = ops[r];
         else
            opcode = 7'($urandom);
         funct3   = 3'($urandom);
         funct7   = ($urandom_range(0, 1) == 1) ?
                    7'h20 : 7'($urandom);
         jump     = 1'($urandom);
         reset    = ($urandom_range(0, 99) == 0);
         stall_E  = ($urandom_range(0, 5) == 0);
         stall_M  = ($urandom_range(0, 5) == 0);
         stall_WB = ($urandom_range(0, 5) == 0);
         flush_E  = ($urandom_range(0, 7) == 0);
         flush_M  = ($urandom_range(0, 7) == 0);
         flush_WB = ($urandom_range(0, 7) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
